// File: rtl/branch_tag_manager_pkg.sv
// Shared branch-tag types for the out-of-order core.
//   BRANCH_TAG_NUM    : default number of in-flight branch tags (power of two)
//   branch_tag_t      : tag id
//   branch_tag_ptr_t  : ring pointer, MSB is the lap color
//   branch_tag_s      : {id, color} as carried alongside a branch uop
package branch_tag_manager_pkg;

    localparam int BRANCH_TAG_NUM = 8;
    localparam int BRANCH_TAG_W   = $clog2(BRANCH_TAG_NUM);

    typedef logic [BRANCH_TAG_W-1:0] branch_tag_t;
    typedef logic [BRANCH_TAG_W:0]   branch_tag_ptr_t;

    typedef struct packed {
        branch_tag_t id;
        logic        color;
    } branch_tag_s;

    // A tag is its own ring position: color on top, id below.
    function automatic branch_tag_ptr_t tag_to_ptr(branch_tag_s t);
        return {t.color, t.id};
    endfunction

endpackage

// File: rtl/branch_tag_manager_if.sv
// Bundle between the branch tag manager and its neighbours.
//   alloc_*  : tag request from decode/rename, grant + {id,color} back
//   res_*    : branch resolution from execute / hazard controller
//   squash_* : one-cycle squash pulse + mask to recovery logic
//   retire_* : oldest resolved tag freed this cycle
//   full/empty/occupancy : ring status
// slave = the tag manager, master = its environment.
interface branch_tag_manager_if
    import branch_tag_manager_pkg::*;
#(
    parameter int NUM_TAGS = BRANCH_TAG_NUM,
    parameter int TAG_W    = $clog2(NUM_TAGS)
);
    logic                alloc_req;
    logic                alloc_gnt;
    logic [TAG_W-1:0]    alloc_id;
    logic                alloc_color;
    logic                res_valid;
    logic [TAG_W-1:0]    res_id;
    logic                res_color;
    logic                res_mispredict;
    logic                squash_valid;
    logic [NUM_TAGS-1:0] squash_mask;
    logic                retire_valid;
    logic [TAG_W-1:0]    retire_id;
    logic                full;
    logic                empty;
    logic [TAG_W:0]      occupancy;

    modport slave (
        input  alloc_req, res_valid, res_id, res_color, res_mispredict,
        output alloc_gnt, alloc_id, alloc_color, squash_valid, squash_mask,
               retire_valid, retire_id, full, empty, occupancy
    );

    modport master (
        output alloc_req, res_valid, res_id, res_color, res_mispredict,
        input  alloc_gnt, alloc_id, alloc_color, squash_valid, squash_mask,
               retire_valid, retire_id, full, empty, occupancy
    );
endinterface

// File: rtl/branch_tag_manager_tag_range_mask.sv
// Combinational mask of ring slots covered by the circular range
// [start_ptr, end_ptr). Pointers carry a lap bit so a full ring
// (end - start == NUM_TAGS) is distinguishable from an empty one.
//   start_ptr : first position in range (TAG_W+1 bits)
//   end_ptr   : one past the last position (TAG_W+1 bits)
//   mask      : bit i set when slot i lies in the range
module branch_tag_manager_tag_range_mask #(
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic [TAG_W:0]      start_ptr,
    input  logic [TAG_W:0]      end_ptr,
    output logic [NUM_TAGS-1:0] mask
);
    logic [TAG_W:0] span;

    assign span = end_ptr - start_ptr;

    // Slot i is in range when its distance from start (mod NUM_TAGS)
    // is less than the span.
    for (genvar i = 0; i < NUM_TAGS; i++) begin : g_slot
        logic [TAG_W-1:0] off;
        assign off     = TAG_W'(i) - start_ptr[TAG_W-1:0];
        assign mask[i] = ({1'b0, off} < span);
    end
endmodule

// File: rtl/branch_tag_manager.sv
// Branch tag manager: a ring of NUM_TAGS branch tags allocated in
// program order at decode, resolved out of order in execute and retired
// in order from the head. A mispredicting resolve truncates the ring
// back to just after the offending tag and reports the dropped tags as a
// one-cycle squash mask.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : branch_tag_manager_if.slave (alloc / resolve / squash /
//                retire / status)
module branch_tag_manager
    import branch_tag_manager_pkg::*;
#(
    parameter int NUM_TAGS = BRANCH_TAG_NUM,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_tag_manager_if.slave  bus
);
    localparam logic [TAG_W:0] PTR_ONE  = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W:0] FULL_CNT = {1'b1, {TAG_W{1'b0}}};

    logic [TAG_W:0]      head, tail, occupancy, res_ptr, squash_start;
    logic [TAG_W-1:0]    head_idx, tail_idx;
    logic [NUM_TAGS-1:0] valid, resolved, color;
    logic [NUM_TAGS-1:0] younger, squash_clr;
    logic                full, hit, mispredict_hit, alloc_gnt, retire_valid;
    logic                squash_valid_q;
    logic [NUM_TAGS-1:0] squash_mask_q;

    assign head_idx  = head[TAG_W-1:0];
    assign tail_idx  = tail[TAG_W-1:0];
    assign occupancy = tail - head;
    assign full      = (occupancy == FULL_CNT);

    // A resolve whose color disagrees with the slot belongs to a tag that
    // was already squashed and the slot re-used; drop it.
    assign hit            = bus.res_valid & valid[bus.res_id] &
                            (color[bus.res_id] == bus.res_color);
    assign mispredict_hit = hit & bus.res_mispredict;

    // full is taken before this cycle's retire: no alloc-on-retire bypass.
    assign alloc_gnt    = bus.alloc_req & ~full & ~mispredict_hit;
    assign retire_valid = valid[head_idx] & resolved[head_idx];

    // Younger-than-resolver range is [res+1, tail).
    assign res_ptr      = {bus.res_color, bus.res_id};
    assign squash_start = res_ptr + PTR_ONE;

    branch_tag_manager_tag_range_mask #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_squash_range (
        .start_ptr (squash_start),
        .end_ptr   (tail),
        .mask      (younger)
    );

    assign squash_clr = younger & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head           <= '0;
            tail           <= '0;
            valid          <= '0;
            resolved       <= '0;
            color          <= '0;
            squash_valid_q <= 1'b0;
            squash_mask_q  <= '0;
        end else begin
            squash_valid_q <= mispredict_hit;
            squash_mask_q  <= mispredict_hit ? squash_clr : '0;

            // Whole-vector squash first; the per-slot writes below win.
            if (mispredict_hit) begin
                valid    <= valid & ~squash_clr;
                resolved <= resolved & ~squash_clr;
                tail     <= squash_start;
            end else if (alloc_gnt) begin
                valid[tail_idx]    <= 1'b1;
                resolved[tail_idx] <= 1'b0;
                color[tail_idx]    <= tail[TAG_W];
                tail               <= tail + PTR_ONE;
            end

            if (hit) begin
                resolved[bus.res_id] <= 1'b1;
            end

            // Retire uses last cycle's resolved bit, so a head resolved
            // this cycle leaves no earlier than next cycle.
            if (retire_valid) begin
                valid[head_idx]    <= 1'b0;
                resolved[head_idx] <= 1'b0;
                head               <= head + PTR_ONE;
            end
        end
    end

    assign bus.alloc_gnt    = alloc_gnt;
    assign bus.alloc_id     = tail_idx;
    assign bus.alloc_color  = tail[TAG_W];
    assign bus.retire_valid = retire_valid;
    assign bus.retire_id    = head_idx;
    assign bus.squash_valid = squash_valid_q;
    assign bus.squash_mask  = squash_mask_q;
    assign bus.full         = full;
    assign bus.empty        = (occupancy == '0);
    assign bus.occupancy    = occupancy;
endmodule

// File: tb/tb_branch_tag_manager.sv
// Scoreboard bench for branch_tag_manager: stimulus pushes expected
// grants / squashes / retires into queues, a negedge monitor pops and
// compares whenever the DUT presents one. Status outputs are checked
// inline by the stimulus.
module tb_branch_tag_manager;
    import branch_tag_manager_pkg::*;

    localparam int NT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_tag_manager_if #(.NUM_TAGS(NT)) bus ();

    branch_tag_manager #(.NUM_TAGS(NT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    branch_tag_s     alloc_q[$];
    logic [NT-1:0]   squash_q[$];
    branch_tag_t     retire_q[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT event must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.alloc_gnt) begin
            if (alloc_q.size() == 0) chk("alloc_unexpected", 1, 0);
            else begin
                branch_tag_s e;
                e = alloc_q.pop_front();
                chk("alloc_id", int'(bus.alloc_id), int'(e.id));
                chk("alloc_color", int'(bus.alloc_color), int'(e.color));
            end
        end
        if (bus.squash_valid) begin
            if (squash_q.size() == 0) chk("squash_unexpected", 1, 0);
            else begin
                logic [NT-1:0] m;
                m = squash_q.pop_front();
                chk("squash_mask", int'(bus.squash_mask), int'(m));
            end
        end else begin
            if (bus.squash_mask != '0) chk("squash_mask_idle", int'(bus.squash_mask), 0);
        end
        if (bus.retire_valid) begin
            if (retire_q.size() == 0) chk("retire_unexpected", 1, 0);
            else begin
                branch_tag_t r;
                r = retire_q.pop_front();
                chk("retire_id", int'(bus.retire_id), int'(r));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req      = 1'b0;
        bus.res_valid      = 1'b0;
        bus.res_id         = '0;
        bus.res_color      = 1'b0;
        bus.res_mispredict = 1'b0;
    endtask

    task automatic drive_res(int id, bit col, bit mis);
        bus.res_valid      = 1'b1;
        bus.res_id         = branch_tag_t'(id);
        bus.res_color      = col;
        bus.res_mispredict = mis;
    endtask

    task automatic alloc_n(int n, int first_id, bit col);
        for (int k = 0; k < n; k++) begin
            bus.alloc_req = 1'b1;
            alloc_q.push_back('{id: branch_tag_t'(first_id + k), color: col});
            tick();
        end
        bus.alloc_req = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        tick();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic chk_status(string tag, int occ, bit f, bit e);
        chk({tag, "_occ"}, int'(bus.occupancy), occ);
        chk({tag, "_full"}, int'(bus.full), int'(f));
        chk({tag, "_empty"}, int'(bus.empty), int'(e));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 0, 1'b0, 1'b1);
        chk("reset_retire", int'(bus.retire_valid), 0);
        chk("reset_gnt", int'(bus.alloc_gnt), 0);
        chk("reset_squash", int'(bus.squash_valid), 0);
        rst_n = 1'b1;

        // Fill the ring: ids 0..7 color 0, then a refused 9th request.
        alloc_n(8, 0, 1'b0);
        bus.alloc_req = 1'b1;
        @(negedge clk);
        chk_status("fill", 8, 1'b1, 1'b0);
        chk("fill_gnt9", int'(bus.alloc_gnt), 0);
        tick();
        bus.alloc_req = 1'b0;

        // Resolve head: retires the following cycle, then re-alloc id 0 color 1.
        drive_res(0, 1'b0, 1'b0);
        retire_q.push_back(branch_tag_t'(0));
        @(negedge clk);
        chk("res_head_same_cycle", int'(bus.retire_valid), 0);
        tick();
        idle();
        @(negedge clk);
        chk("retire_while_full", int'(bus.full), 1);
        tick();
        bus.alloc_req = 1'b1;
        alloc_q.push_back('{id: branch_tag_t'(0), color: 1'b1});
        @(negedge clk);
        chk("wrap_occ_before", int'(bus.occupancy), 7);
        tick();
        bus.alloc_req = 1'b0;
        @(negedge clk);
        chk_status("wrap", 8, 1'b1, 1'b0);
        tick();

        // Mispredict id 6 across the wrap: squashes 7 (color 0) and 0 (color 1).
        drive_res(6, 1'b0, 1'b1);
        squash_q.push_back(8'b1000_0001);
        tick();
        idle();
        @(negedge clk);
        chk("wrap_squash_occ", int'(bus.occupancy), 6);
        tick();
        alloc_n(1, 7, 1'b0);

        // Mispredict id 2 with 0..5 live and a colliding alloc.
        do_reset();
        alloc_n(6, 0, 1'b0);
        bus.alloc_req = 1'b1;
        drive_res(2, 1'b0, 1'b1);
        squash_q.push_back(8'b0011_1000);
        @(negedge clk);
        chk("mis_alloc_blocked", int'(bus.alloc_gnt), 0);
        tick();
        idle();
        @(negedge clk);
        chk("mis_occ", int'(bus.occupancy), 3);
        tick();
        bus.alloc_req = 1'b1;
        alloc_q.push_back('{id: branch_tag_t'(3), color: 1'b0});
        @(negedge clk);
        chk("squash_one_cycle", int'(bus.squash_valid), 0);
        tick();
        bus.alloc_req = 1'b0;

        // Stale resolve: id 4 holds color 0, resolve arrives with color 1.
        alloc_n(1, 4, 1'b0);
        drive_res(4, 1'b1, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("stale_no_squash", int'(bus.squash_valid), 0);
        chk("stale_occ", int'(bus.occupancy), 5);
        tick();
        // Drain 0..3 (2 already resolved); id 4 must stay unresolved.
        for (int k = 0; k < 4; k++) retire_q.push_back(branch_tag_t'(k));
        drive_res(0, 1'b0, 1'b0); tick();
        drive_res(1, 1'b0, 1'b0); tick();
        drive_res(3, 1'b0, 1'b0); tick();
        idle();
        repeat (5) tick();
        @(negedge clk);
        chk("stale_left_occ", int'(bus.occupancy), 1);
        chk("stale_not_resolved", int'(bus.retire_valid), 0);
        tick();

        // Out-of-order resolve: 1 then 0; retire 0 then 1.
        do_reset();
        alloc_n(2, 0, 1'b0);
        drive_res(1, 1'b0, 1'b0);
        tick();
        drive_res(0, 1'b0, 1'b0);
        retire_q.push_back(branch_tag_t'(0));
        retire_q.push_back(branch_tag_t'(1));
        @(negedge clk);
        chk("ooo_no_early_retire", int'(bus.retire_valid), 0);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk);
        chk_status("ooo_drained", 0, 1'b0, 1'b1);
        tick();

        // Asynchronous reset in the middle of a mispredict.
        alloc_n(3, 2, 1'b0);
        drive_res(2, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("async_rst", 0, 1'b0, 1'b1);
        chk("async_rst_retire", int'(bus.retire_valid), 0);
        chk("async_rst_squash", int'(bus.squash_valid), 0);
        idle();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_squash", int'(bus.squash_valid), 0);
        tick();
        @(negedge clk);
        chk("post_rst_no_squash2", int'(bus.squash_valid), 0);
        chk("post_rst_empty", int'(bus.empty), 1);
        tick();

        chk("alloc_q_drained", alloc_q.size(), 0);
        chk("squash_q_drained", squash_q.size(), 0);
        chk("retire_q_drained", retire_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
